// File: rtl/gpio_ctrl_if.sv
// Bus and pin bundle for gpio_ctrl: MIPS data-bus read/write strobes plus the GPIO pins.
// master = bus/pin driver side, slave = the controller.
interface gpio_ctrl_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NPORTS = 2
);
    localparam int unsigned AW = $clog2(NPORTS) + 3;

    logic                    we;
    logic                    re;
    logic [AW-1:0]           a;
    logic [WIDTH-1:0]        wd;
    logic [WIDTH-1:0]        rd;
    logic                    rd_valid;
    logic [NPORTS*WIDTH-1:0] gp_in;
    logic [NPORTS*WIDTH-1:0] gp_out;
    logic [NPORTS*WIDTH-1:0] gp_oe;
    logic                    irq;

    modport master (
        output we, re, a, wd, gp_in,
        input  rd, rd_valid, gp_out, gp_oe, irq
    );

    modport slave (
        input  we, re, a, wd, gp_in,
        output rd, rd_valid, gp_out, gp_oe, irq
    );
endinterface

// File: rtl/gpio_ctrl.sv
// Multi-channel memory-mapped GPIO controller.
// Each channel: OUT latch, DIR mask, synchronised IN, rise/fall enables and a sticky
// write-1-to-clear STATUS; irq is the OR of every STATUS bit.
// Optional macro GPIO_ATOMIC_EN enables the SET (offset 6) / CLR (offset 7) writes;
// without it those offsets are reserved (writes ignored, reads 0).
module gpio_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NPORTS      = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    gpio_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(NPORTS) + 3;
    localparam int unsigned CW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0][WIDTH-1:0]                   r_out;
    logic [NPORTS-1:0][WIDTH-1:0]                   r_dir;
    logic [NPORTS-1:0][WIDTH-1:0]                   r_rise_en;
    logic [NPORTS-1:0][WIDTH-1:0]                   r_fall_en;
    logic [NPORTS-1:0][WIDTH-1:0]                   r_status;
    logic [SYNC_STAGES-1:0][NPORTS-1:0][WIDTH-1:0]  r_sync;
    logic [NPORTS-1:0][WIDTH-1:0]                   r_prev;
    logic [WIDTH-1:0]                               r_rd;
    logic                                           r_rd_valid;

    logic [CW-1:0]                w_ch;
    logic [2:0]                   w_off;
    logic [NPORTS-1:0][WIDTH-1:0] w_sync;
    logic [NPORTS-1:0][WIDTH-1:0] w_rise;
    logic [NPORTS-1:0][WIDTH-1:0] w_fall;
    logic [NPORTS-1:0][WIDTH-1:0] w_clr;
    logic [WIDTH-1:0]             w_rdata;

    assign w_off = bus.a[2:0];

    // With a single channel there is no channel field in the address.
    generate
        if (NPORTS > 1) begin : g_ch_multi
            assign w_ch = bus.a[AW-1:3];
        end else begin : g_ch_single
            assign w_ch = '0;
        end
    endgenerate

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;

    // Pin synchroniser chain plus one-cycle edge history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= bus.gp_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    // Control register writes; IN and STATUS are not written here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (bus.we) begin
            case (w_off)
                3'd0: r_out[w_ch]     <= bus.wd;
                3'd1: r_dir[w_ch]     <= bus.wd;
                3'd3: r_rise_en[w_ch] <= bus.wd;
                3'd4: r_fall_en[w_ch] <= bus.wd;
`ifdef GPIO_ATOMIC_EN
                3'd6: r_out[w_ch]     <= r_out[w_ch] | bus.wd;
                3'd7: r_out[w_ch]     <= r_out[w_ch] & ~bus.wd;
`endif
                default: ;
            endcase
        end
    end

    // Write-1-to-clear mask for the addressed channel's STATUS.
    always_comb begin
        w_clr = '0;
        if (bus.we && (w_off == 3'd5)) begin
            w_clr[w_ch] = bus.wd;
        end
    end

    // Sticky edge status; a new edge in the clearing cycle keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
        end
    end

    // Read mux over current (pre-write) register contents.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            3'd0:    w_rdata = r_out[w_ch];
            3'd1:    w_rdata = r_dir[w_ch];
            3'd2:    w_rdata = w_sync[w_ch];
            3'd3:    w_rdata = r_rise_en[w_ch];
            3'd4:    w_rdata = r_fall_en[w_ch];
            3'd5:    w_rdata = r_status[w_ch];
            default: w_rdata = '0;
        endcase
    end

    // Registered read data with a one-cycle valid pulse; rd holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.re;
            if (bus.re) begin
                r_rd <= w_rdata;
            end
        end
    end

    assign bus.rd       = r_rd;
    assign bus.rd_valid = r_rd_valid;
    assign bus.gp_out   = r_out;
    assign bus.gp_oe    = r_dir;
    assign bus.irq      = |r_status;
endmodule
